// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS core: holds one sweep configuration and
// steps the frequency word from start to stop, dwelling a fixed number of cycles per step.
module dds_sweep_ctrl #(
  parameter int FREQ_W  = 28,
  parameter int AMPL_W  = 12,
  parameter int DWELL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [FREQ_W-1:0] cfg_start_freq,
  input  logic [FREQ_W-1:0] cfg_stop_freq,
  input  logic [FREQ_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [AMPL_W-1:0] cfg_ampl,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              abort,
  output logic [FREQ_W-1:0] Freq_KW,
  output logic [AMPL_W-1:0] Ampl_KW,
  output logic              busy,
  output logic              step_tick,
  output logic              sweep_done
);

  typedef enum logic [1:0] {IDLE, ARMED, SWEEP} state_t;

  typedef struct packed {
    logic [FREQ_W-1:0]  start_freq;
    logic [FREQ_W-1:0]  stop_freq;
    logic [FREQ_W-1:0]  step;
    logic [DWELL_W-1:0] dwell;
    logic [AMPL_W-1:0]  ampl;
    logic               loop;
  } cfg_t;

  state_t             state, state_nxt;
  cfg_t               cfg;
  logic [DWELL_W-1:0] dwell_cnt, dwell_eff;
  logic [FREQ_W:0]    next_sum;
  logic               last, one_step, dwell_end;
  logic               capture, go;

  assign cfg_ready = (state != SWEEP);
  assign busy      = (state == SWEEP);
  assign dwell_eff = (cfg.dwell == '0) ? DWELL_W'(1) : cfg.dwell;
  assign dwell_end = (dwell_cnt >= dwell_eff);
  // Extra bit catches a wrap past the top of the frequency range.
  assign next_sum  = {1'b0, Freq_KW} + {1'b0, cfg.step};
  assign one_step  = (cfg.step == '0) || (cfg.start_freq >= cfg.stop_freq);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    go        = 1'b0;
    if (abort) begin
      state_nxt = (state == IDLE) ? IDLE : ARMED;
    end else begin
      case (state)
        IDLE:  if (cfg_valid) begin capture = 1'b1; state_nxt = ARMED; end
        ARMED: begin
          if (cfg_valid)  capture = 1'b1;
          else if (start) begin go = 1'b1; state_nxt = SWEEP; end
        end
        SWEEP: if (dwell_end && last && !cfg.loop) state_nxt = ARMED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg        <= '0;
      Freq_KW    <= '0;
      Ampl_KW    <= '0;
      step_tick  <= 1'b0;
      sweep_done <= 1'b0;
      dwell_cnt  <= '0;
      last       <= 1'b0;
    end else begin
      step_tick  <= 1'b0;
      sweep_done <= 1'b0;
      if (capture) begin
        cfg.start_freq <= cfg_start_freq;
        cfg.stop_freq  <= cfg_stop_freq;
        cfg.step       <= cfg_step;
        cfg.dwell      <= cfg_dwell;
        cfg.ampl       <= cfg_ampl;
        cfg.loop       <= cfg_loop;
      end
      if (abort) begin
        Freq_KW <= '0;
        Ampl_KW <= '0;
      end else if (go) begin
        Freq_KW   <= cfg.start_freq;
        Ampl_KW   <= cfg.ampl;
        step_tick <= 1'b1;
        dwell_cnt <= DWELL_W'(1);
        last      <= one_step;
      end else if (busy) begin
        if (!dwell_end) begin
          dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end else if (last) begin
          sweep_done <= 1'b1;
          // Single pass leaves the final word on the DDS output.
          if (cfg.loop) begin
            Freq_KW   <= cfg.start_freq;
            step_tick <= 1'b1;
            dwell_cnt <= DWELL_W'(1);
            last      <= one_step;
          end
        end else begin
          step_tick <= 1'b1;
          dwell_cnt <= DWELL_W'(1);
          if (next_sum >= {1'b0, cfg.stop_freq}) begin
            Freq_KW <= cfg.stop_freq;
            last    <= 1'b1;
          end else begin
            Freq_KW <= next_sum[FREQ_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: expected per-cycle outputs are queued
// ahead of each step and popped/compared one cycle at a time.
module tb_dds_sweep_ctrl;
  localparam int FREQ_W  = 28;
  localparam int AMPL_W  = 12;
  localparam int DWELL_W = 16;
  localparam int OBS_W   = FREQ_W + AMPL_W + 4;

  logic               clk, rst_n;
  logic               cfg_valid, cfg_ready;
  logic [FREQ_W-1:0]  cfg_start_freq, cfg_stop_freq, cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [AMPL_W-1:0]  cfg_ampl;
  logic               cfg_loop, start, abort;
  logic [FREQ_W-1:0]  Freq_KW;
  logic [AMPL_W-1:0]  Ampl_KW;
  logic               busy, step_tick, sweep_done;

  logic [OBS_W-1:0]   exp_q[$];
  logic [OBS_W-1:0]   obs, e;
  int                 checks = 0;
  int                 failures = 0;

  dds_sweep_ctrl #(.FREQ_W(FREQ_W), .AMPL_W(AMPL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_ampl(cfg_ampl), .cfg_loop(cfg_loop),
    .start(start), .abort(abort), .Freq_KW(Freq_KW), .Ampl_KW(Ampl_KW),
    .busy(busy), .step_tick(step_tick), .sweep_done(sweep_done)
  );

  assign obs = {Freq_KW, Ampl_KW, busy, step_tick, sweep_done, cfg_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [FREQ_W-1:0] f, input logic [AMPL_W-1:0] a,
                      input logic b, input logic t, input logic d, input logic r);
    exp_q.push_back({f, a, b, t, d, r});
  endtask

  // One clock: single-cycle strobes drop after the edge, then outputs are compared.
  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    start = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s obs=%h exp=%h (freq ampl busy tick done ready)", tag, obs, e);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic set_cfg(input logic [FREQ_W-1:0] s, input logic [FREQ_W-1:0] p,
                         input logic [FREQ_W-1:0] st, input logic [DWELL_W-1:0] dw,
                         input logic [AMPL_W-1:0] a, input logic lp);
    cfg_start_freq = s; cfg_stop_freq = p; cfg_step = st;
    cfg_dwell = dw; cfg_ampl = a; cfg_loop = lp; cfg_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    cfg_start_freq = '0; cfg_stop_freq = '0; cfg_step = '0;
    cfg_dwell = '0; cfg_ampl = '0; cfg_loop = 1'b0;

    // Reset overrides active inputs
    set_cfg(10, 40, 10, 3, 12'h5A5, 1'b0); start = 1'b1;
    push(0, 0, 0, 0, 0, 1); cyc("reset0");
    set_cfg(10, 40, 10, 3, 12'h5A5, 1'b0); start = 1'b1;
    push(0, 0, 0, 0, 0, 1); cyc("reset1");
    rst_n = 1'b1;

    start = 1'b1; push(0, 0, 0, 0, 0, 1); cyc("idle_start");

    // 10..40 step 10, dwell 3, start alongside capture is ignored
    set_cfg(10, 40, 10, 3, 12'h5A5, 1'b0); start = 1'b1;
    push(0, 0, 0, 0, 0, 1); cyc("cap1");
    start = 1'b1;
    for (int f = 10; f <= 40; f += 10)
      for (int k = 0; k < 3; k++) push(FREQ_W'(f), 12'h5A5, 1, k == 0, 0, 0);
    push(40, 12'h5A5, 0, 0, 1, 1);
    push(40, 12'h5A5, 0, 0, 0, 1);
    run(14, "sweep_dwell3");

    // Clamp to stop on the last step; new config must not disturb held outputs
    set_cfg(10, 35, 10, 1, 12'h123, 1'b0);
    push(40, 12'h5A5, 0, 0, 0, 1); cyc("cap_hold");
    start = 1'b1;
    push(10, 12'h123, 1, 1, 0, 0); push(20, 12'h123, 1, 1, 0, 0);
    push(30, 12'h123, 1, 1, 0, 0); push(35, 12'h123, 1, 1, 0, 0);
    push(35, 12'h123, 0, 0, 1, 1);
    run(5, "sweep_clamp");

    // Step 0 with dwell 0: one-step pass of one cycle
    set_cfg(7, 100, 0, 0, 12'h0F0, 1'b0);
    push(35, 12'h123, 0, 0, 0, 1); cyc("cap_onestep");
    start = 1'b1;
    push(7, 12'h0F0, 1, 1, 0, 0); push(7, 12'h0F0, 0, 0, 1, 1);
    run(2, "one_step");

    // Top of range: carry must clamp to stop, never wrap
    set_cfg(28'hFFFFFF0, 28'hFFFFFFF, 28'h20, 2, 12'h7FF, 1'b0);
    push(7, 12'h0F0, 0, 0, 0, 1); cyc("cap_wrap");
    start = 1'b1;
    push(28'hFFFFFF0, 12'h7FF, 1, 1, 0, 0); push(28'hFFFFFF0, 12'h7FF, 1, 0, 0, 0);
    push(28'hFFFFFFF, 12'h7FF, 1, 1, 0, 0); push(28'hFFFFFFF, 12'h7FF, 1, 0, 0, 0);
    push(28'hFFFFFFF, 12'h7FF, 0, 0, 1, 1); push(28'hFFFFFFF, 12'h7FF, 0, 0, 0, 1);
    run(6, "no_wrap");

    // Continuous sweep 5,10,15,5,...
    set_cfg(5, 15, 5, 1, 12'hABC, 1'b1);
    push(28'hFFFFFFF, 12'h7FF, 0, 0, 0, 1); cyc("cap_loop");
    start = 1'b1;
    for (int p = 0; p < 2; p++) begin
      push(5, 12'hABC, 1, 1, p == 1, 0);
      push(10, 12'hABC, 1, 1, 0, 0);
      push(15, 12'hABC, 1, 1, 0, 0);
    end
    run(6, "loop");

    // Abort + start at pass end: abort wins, mutes, no sweep_done
    abort = 1'b1; start = 1'b1;
    push(0, 0, 0, 0, 0, 1); cyc("abort");
    start = 1'b1;
    push(5, 12'hABC, 1, 1, 0, 0); push(10, 12'hABC, 1, 1, 0, 0);
    run(2, "replay");

    // cfg_valid during SWEEP is ignored
    set_cfg(1000, 2000, 1, 9, 12'h111, 1'b0);
    push(15, 12'hABC, 1, 1, 0, 0); cyc("cfg_in_sweep0");
    set_cfg(1000, 2000, 1, 9, 12'h111, 1'b0);
    push(5, 12'hABC, 1, 1, 1, 0); cyc("cfg_in_sweep1");

    // Reset mid-sweep clears everything, including held config
    rst_n = 1'b0;
    push(0, 0, 0, 0, 0, 1); cyc("reset_mid");
    rst_n = 1'b1; start = 1'b1;
    push(0, 0, 0, 0, 0, 1); cyc("post_reset_start");

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameters: FREQ_W, default 28, frequency-word width; AMPL_W, default 12, amplitude-word width (matches DAC_WIDTH); DWELL_W, default 16, dwell-counter width.
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port cfg_valid, input, 1, config offer.
REQ-005 SHALL have port cfg_ready, output, 1, config may be accepted.
REQ-006 SHALL have port cfg_start_freq, input, FREQ_W, first frequency word.
REQ-007 SHALL have port cfg_stop_freq, input, FREQ_W, final frequency word.
REQ-008 SHALL have port cfg_step, input, FREQ_W, increment per dwell.
REQ-009 SHALL have port cfg_dwell, input, DWELL_W, cycles per frequency.
REQ-010 SHALL have port cfg_ampl, input, AMPL_W, amplitude word during sweep.
REQ-011 SHALL have port cfg_loop, input, 1; 1 = continuous sweep, 0 = single pass.
REQ-012 SHALL have port start, input, 1, begin sweep.
REQ-013 SHALL have port abort, input, 1, stop sweep and mute.
REQ-014 SHALL have port Freq_KW, output, FREQ_W, registered frequency word to DDS.
REQ-015 SHALL have port Ampl_KW, output, AMPL_W, registered amplitude word to DDS.
REQ-016 SHALL have port busy, output, 1, high in SWEEP.
REQ-017 SHALL have port step_tick, output, 1, one-cycle pulse when Freq_KW loads a new value.
REQ-018 SHALL have port sweep_done, output, 1, one-cycle pulse at the end of each pass.

Function
REQ-019 SHALL implement states IDLE (no config held), ARMED (config held), and SWEEP.
REQ-020 SHALL drive cfg_ready = 1 in IDLE and ARMED, and 0 in SWEEP; cfg_valid in SWEEP SHALL be ignored.
REQ-021 SHALL capture all cfg_* on cfg_valid && cfg_ready and enter/stay ARMED the next cycle; start in the same cycle SHALL be ignored.
REQ-022 SHALL ignore start in IDLE; start in ARMED (no cfg_valid, no abort) at cycle N SHALL give state SWEEP, busy=1, Freq_KW=cfg_start_freq, Ampl_KW=cfg_ampl, step_tick=1 at cycle N+1.
REQ-023 SHALL hold each frequency exactly max(cfg_dwell,1) cycles; dwell 0 SHALL be treated as 1.
REQ-024 SHALL compute next = Freq_KW + cfg_step with FREQ_W+1 bits; if carry, or next >= cfg_stop_freq, Freq_KW SHALL load cfg_stop_freq, marking it as the last step.
REQ-025 SHALL treat cfg_step = 0, or cfg_start_freq >= cfg_stop_freq, as a one-step pass: start frequency held one dwell, then end of pass.
REQ-026 SHALL, at the end of the last step's dwell with cfg_loop=0, pulse sweep_done, go to ARMED, and clear busy in that cycle; Freq_KW and Ampl_KW SHALL hold their last values.
REQ-027 SHALL, at the end of a pass with cfg_loop=1, pulse sweep_done and step_tick, reload Freq_KW=cfg_start_freq, and stay in SWEEP.
REQ-028 SHALL, on abort in any state, set Freq_KW=0 and Ampl_KW=0 next cycle, go to ARMED if a config is held (else IDLE), and not pulse sweep_done.
REQ-029 SHALL give abort priority over start, cfg capture, and pass completion in the same cycle.
REQ-030 SHALL drive Freq_KW=0 and Ampl_KW=0 in IDLE; a new config captured in ARMED SHALL not alter Freq_KW/Ampl_KW until the next start.

Reset
REQ-031 SHALL, while rst_n=0 at a clk edge, set state IDLE, Freq_KW=0, Ampl_KW=0, busy=0, step_tick=0, sweep_done=0, cfg_ready=1, and clear held config.
REQ-032 SHALL let reset override all inputs including mid-sweep; no sweep_done SHALL be issued for the interrupted pass.

Verification
REQ-033 SHALL check: cfg start=10, stop=40, step=10, dwell=3, loop=0; start at cycle 0 -> Freq_KW 10 @1-3, 20 @4-6, 30 @7-9, 40 @10-12; sweep_done and busy=0 @13; Freq_KW stays 40.
REQ-034 SHALL check: start=10, stop=35, step=10, dwell=1 -> Freq_KW 10,20,30,35 on consecutive cycles, then one sweep_done pulse.
REQ-035 SHALL check: start=0xFFFFFF0, stop=0xFFFFFFF, step=0x20, dwell=2 -> 0xFFFFFF0 for 2 cycles, 0xFFFFFFF for 2 cycles, no wrap to a small value.
REQ-036 SHALL check: loop=1, start=5, stop=15, step=5, dwell=1 -> 5,10,15,5,10,... with sweep_done each time 15->5, and busy stays 1.
REQ-037 SHALL check: abort and start in the same cycle mid-sweep -> next cycle Freq_KW=0, Ampl_KW=0, state ARMED, no sweep_done; a later start replays from cfg_start_freq.
REQ-038 SHALL check: rst_n low mid-sweep, and cfg_valid during SWEEP -> all outputs return to reset values; cfg_valid during SWEEP does not change the sweep.
